reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes and busy-sets.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 radd1, radd2  input  ADDR_W each  read addresses for ports 1 and 2.
REQ-007 dataout1, dataout2  output  DATA_W each  read data for ports 1 and 2.
REQ-008 busy1, busy2  output  1 each  scoreboard busy bit of radd1 and radd2.
REQ-009 wr  input  1  write enable.
REQ-010 wadd  input  ADDR_W  write address.
REQ-011 datain  input  DATA_W  write data.
REQ-012 set_busy  input  1  marks a register as having an in-flight producer.
REQ-013 sadd  input  ADDR_W  address for set_busy.

Function
REQ-014 Reads are combinational, with zero cycles of latency from radd to dataout/busy.
REQ-015 With wr=1, datain is stored at wadd on the rising edge, and busy[wadd] clears on the same edge.
REQ-016 With set_busy=1, busy[sadd] sets on the rising edge.
REQ-017 If set_busy and wr target the same address in one cycle, the data is written and busy ends at 1 (set wins).
REQ-018 If ZERO_REG=1, address 0 always reads dataout=0 and busy=0, and wr or set_busy to address 0 has no effect.
REQ-019 If ZERO_REG=0, register 0 behaves like every other register.
REQ-020 Both read ports may address the same register in one cycle and return identical values.
REQ-021 The full address range is valid, with no wrap-around or out-of-range case; address 2**ADDR_W-1 behaves like any other.
REQ-022 wr with busy[wadd]=0 is legal; it writes and leaves busy at 0.

Reset
REQ-023 While rst=1 at a clock edge, all registers clear to 0 and all busy bits clear to 0, regardless of wr or set_busy.
REQ-024 During reset, dataout1 and dataout2 reflect the stored values, which are 0 after the first reset edge; busy1 and busy2 are 0 after that edge.
REQ-025 Asserting rst mid-operation discards all pending busy state and stored data, and no write in that cycle takes effect.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN controls write-to-read forwarding.
- Defined: when wr=1, wadd equals radd1 or radd2, and the address is not a ZERO_REG-masked register 0, the matching port returns datain and busy=0 combinationally in that same cycle. If set_busy also targets that address, busy shows 1.
- Undefined: the port returns the old stored value and the old busy bit until the edge.

Structure
REQ-027 Package reg_file_pkg holds the default DATA_W and ADDR_W constants, an address typedef and a data typedef; the module imports it.
REQ-028 Sub-module reg_file_scoreboard holds the busy-bit vector with its set/clear/reset logic. reg_file_sb instantiates it once; the storage array and read muxing stay in reg_file_sb.

Verification
REQ-029 Reset then read: rst=1 for 1 cycle, then radd1=1, radd2=4 -> dataout1=0, dataout2=0, busy1=0, busy2=0.
REQ-030 Write/read: wr=1, wadd=1, datain=32'h00887000, then next cycle radd1=1 -> dataout1=32'h00887000, busy1=0.
REQ-031 Scoreboard: set_busy=1, sadd=5, then radd2=5 -> busy2=1; then wr=1, wadd=5, datain=32'h12345678 -> next cycle busy2=0, dataout2=32'h12345678.
REQ-032 Collision: set_busy=1, sadd=7 and wr=1, wadd=7, datain=32'hA5A5A5A5 in the same cycle -> next cycle radd1=7 gives busy1=1 and dataout1=32'hA5A5A5A5.
REQ-033 Zero register (ZERO_REG=1): wr=1, wadd=0, datain=32'hFFFFFFFF, and set_busy with sadd=0 -> radd1=0 gives dataout1=0, busy1=0.
REQ-034 Bypass: wr=1, wadd=3, datain=32'hDEADBEEF, radd1=3 in the same cycle -> dataout1=32'hDEADBEEF with REG_FILE_BYPASS_EN defined, or the old value (0 after reset) without it.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg
// Shared defaults and types for the scoreboarded register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 5;

  typedef logic [c_ADDR_W-1:0] addr_t;
  typedef logic [c_DATA_W-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// reg_file_scoreboard
// Busy-bit vector: per-register in-flight producer flags with set/clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    wadd,
  input  logic                 set_busy,
  input  logic [ADDR_W-1:0]    sadd,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int c_DEPTH = 2**ADDR_W;

  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_set;
  logic [c_DEPTH-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (set_busy) w_set[sadd] = 1'b1;
    if (wr)       w_clr[wadd] = 1'b1;
    if (ZERO_REG) begin
      w_set[0] = 1'b0;
      w_clr[0] = 1'b0;
    end
  end

  // Set is applied after clear so a same-address collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// reg_file_sb
// Two-read/one-write register file with busy scoreboard.
// Optional write-to-read forwarding enabled by macro REG_FILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int ADDR_W   = c_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] radd1,
  input  logic [ADDR_W-1:0] radd2,
  output logic [DATA_W-1:0] dataout1,
  output logic [DATA_W-1:0] dataout2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wadd,
  input  logic [DATA_W-1:0] datain,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] sadd
);

  localparam int c_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] w_busy_vec;
  logic               w_wr_ok;
  logic [DATA_W-1:0]  w_data1;
  logic [DATA_W-1:0]  w_data2;
  logic               w_busy1;
  logic               w_busy2;

  // A write to a hardwired zero register is dropped entirely.
  assign w_wr_ok = wr && !(ZERO_REG && (wadd == '0));

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .wadd     (wadd),
    .set_busy (set_busy),
    .sadd     (sadd),
    .busy_vec (w_busy_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wadd] <= datain;
    end
  end

  always_comb begin
    w_data1 = r_mem[radd1];
    w_busy1 = w_busy_vec[radd1];
    w_data2 = r_mem[radd2];
    w_busy2 = w_busy_vec[radd2];
    if (ZERO_REG && (radd1 == '0)) begin
      w_data1 = '0;
      w_busy1 = 1'b0;
    end
    if (ZERO_REG && (radd2 == '0)) begin
      w_data2 = '0;
      w_busy2 = 1'b0;
    end
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write; busy reflects a same-cycle set on that address.
    if (w_wr_ok && (wadd == radd1)) begin
      w_data1 = datain;
      w_busy1 = set_busy && (sadd == radd1);
    end
    if (w_wr_ok && (wadd == radd2)) begin
      w_data2 = datain;
      w_busy2 = set_busy && (sadd == radd2);
    end
`endif
  end

  assign dataout1 = w_data1;
  assign dataout2 = w_data2;
  assign busy1    = w_busy1;
  assign busy2    = w_busy2;

endmodule

`default_nettype wire
